// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared definitions for the pipelined adder/subtractor.
// Holds the operation mode encoding and the segment-width helper used to
// split WIDTH into STAGES equal slices.
package pipelined_adder_pkg;

    // Operation mode carried on the Sub input.
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

    // Default geometry of the block.
    localparam int DEF_WIDTH  = 64;
    localparam int DEF_STAGES = 4;

    // Width of one pipeline segment.
    function automatic int seg_w(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// pipelined_adder_stage: one SEG_W-bit slice of the pipelined adder.
// Adds its operand segment plus the incoming carry and registers the
// segment sum, the carry out and the stage valid bit. All registers
// advance only when en_i is high, so the whole pipe stalls together.
module pipelined_adder_stage #(
    parameter int SEG_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             valid_i,
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [SEG_W-1:0] sum_o,
    output logic             carry_o
);

    logic [SEG_W:0]   add_d;
    logic             valid_q;
    logic [SEG_W-1:0] sum_q;
    logic             carry_q;

    // Segment add with one extra bit to catch the carry out of the slice.
    always_comb begin
        add_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, carry_i};
    end

    // Stage register: captures the slice result on advance, holds on stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
            sum_q   <= add_d[SEG_W-1:0];
            carry_q <= add_d[SEG_W];
        end
    end

    assign valid_o = valid_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: parametrised pipelined two-operand adder/subtractor.
// WIDTH is split into STAGES equal segments; stage k adds segment k using
// the registered carry of stage k-1. Higher operand segments travel skewed
// through delay registers, completed low result segments travel forward,
// so Sum/CarryOut come out of the last stage aligned.
//
// Handshake: an operand transfers when InValid & InReady at a rising edge,
// a result transfers when OutValid & OutReady at a rising edge. The pipe
// advances when the output slot is empty or being drained
// (advance = ~OutValid | OutReady), and InReady is that same signal, so the
// whole pipe moves or stalls as one and sustains one operation per cycle.
//
// Optional feature: define PIPE_ADDER_OVERFLOW_EN to add the Overflow port
// (signed overflow of the result, valid together with OutValid).
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             CarryIn,
    input  logic             Sub,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Sum,
    output logic             CarryOut
`ifdef PIPE_ADDER_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    localparam int SW = seg_w(WIDTH, STAGES);

    // The segment split only works for an exact division of the width.
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    mode_e            mode;
    logic             advance;
    logic [WIDTH-1:0] y_eff;
    logic             cin_eff;

    assign advance = ~OutValid | OutReady;
    assign InReady = advance;
    assign mode    = mode_e'(Sub);

    // Entry conditioning: subtraction becomes X + ~Y + 1, so the mode bit
    // is not needed by any later stage.
    always_comb begin
        y_eff   = Y;
        cin_eff = CarryIn;
        if (mode == MODE_SUB) begin
            y_eff   = ~Y;
            cin_eff = 1'b1;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand segments k..STAGES-1 as seen by stage k (low SW bits are
        // the ones this stage adds, the rest are passed on).
        logic [WIDTH-k*SW-1:0] xs;
        logic [WIDTH-k*SW-1:0] ys;
        // Result segments 0..k once stage k has registered its slice.
        logic [(k+1)*SW-1:0]   res;
        logic                  vin;
        logic                  cin;
        logic                  v_q;
        logic                  c_q;
        logic [SW-1:0]         s_q;

        if (k == 0) begin : g_entry
            assign xs  = X;
            assign ys  = y_eff;
            assign vin = InValid;
            assign cin = cin_eff;
            assign res = s_q;
        end else begin : g_inner
            logic [WIDTH-k*SW-1:0] xs_q;
            logic [WIDTH-k*SW-1:0] ys_q;
            logic [k*SW-1:0]       lo_q;

            // Skew/deskew registers: delay the untouched high operand
            // segments and the finished low result segments by one stage.
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    xs_q <= '0;
                    ys_q <= '0;
                    lo_q <= '0;
                end else if (advance) begin
                    xs_q <= g_stage[k-1].xs[WIDTH-(k-1)*SW-1:SW];
                    ys_q <= g_stage[k-1].ys[WIDTH-(k-1)*SW-1:SW];
                    lo_q <= g_stage[k-1].res;
                end
            end

            assign xs  = xs_q;
            assign ys  = ys_q;
            assign vin = g_stage[k-1].v_q;
            assign cin = g_stage[k-1].c_q;
            assign res = {s_q, lo_q};
        end

        pipelined_adder_stage #(
            .SEG_W(SW)
        ) u_stage (
            .clk_i   (Clock),
            .rst_i   (Reset),
            .en_i    (advance),
            .valid_i (vin),
            .a_i     (xs[SW-1:0]),
            .b_i     (ys[SW-1:0]),
            .carry_i (cin),
            .valid_o (v_q),
            .sum_o   (s_q),
            .carry_o (c_q)
        );
    end

    assign Sum      = g_stage[STAGES-1].res;
    assign CarryOut = g_stage[STAGES-1].c_q;
    assign OutValid = g_stage[STAGES-1].v_q;

`ifdef PIPE_ADDER_OVERFLOW_EN
    // The carry into the MSB equals a_msb ^ b_msb ^ sum_msb, so registering
    // the operand MSB parity next to the last stage is enough to recover it.
    logic msb_x_q;

    // MSB operand parity, captured with the last stage and held on stall.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            msb_x_q <= 1'b0;
        end else if (advance) begin
            msb_x_q <= g_stage[STAGES-1].xs[SW-1] ^ g_stage[STAGES-1].ys[SW-1];
        end
    end

    assign Overflow = msb_x_q ^ Sum[WIDTH-1] ^ CarryOut;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed table of hand-computed vectors plus
// hand-written sequences for latency, backpressure, reset mid-stream and
// random output stalls, all checked through an expected-result queue.
module tb_pipelined_adder;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;
    localparam int NVEC   = 12;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    vec_t vecs[NVEC];

    logic             Clock = 1'b0;
    logic             Reset;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             CarryIn;
    logic             Sub;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Sum;
    logic             CarryOut;
`ifdef PIPE_ADDER_OVERFLOW_EN
    logic             Overflow;
`endif

    int pass_cnt     = 0;
    int total_cnt    = 0;
    int results_seen = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] mon_exp;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .X        (X),
        .Y        (Y),
        .CarryIn  (CarryIn),
        .Sub      (Sub),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Sum      (Sum),
        .CarryOut (CarryOut)
`ifdef PIPE_ADDER_OVERFLOW_EN
        ,
        .Overflow (Overflow)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    task automatic do_reset();
        Reset    = 1'b1;
        InValid  = 1'b0;
        X        = '0;
        Y        = '0;
        CarryIn  = 1'b0;
        Sub      = 1'b0;
        OutReady = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic cin, input logic sub);
        logic [WIDTH:0] r;
        if (sub) r = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        else     r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        return r;
    endfunction

    // ---------------- scoreboard: compare every output transfer ----------------
    always @(negedge Clock) begin
        if (!Reset && OutValid && OutReady) begin
            results_seen++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL result_unexpected: got sum 0x%0h cout %0d, expected no result", Sum, CarryOut);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", {CarryOut, Sum}, mon_exp);
            end
        end
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic cin,
                        input logic sub, input logic [WIDTH:0] exp, output int waits);
        InValid = 1'b1;
        X       = x;
        Y       = y;
        CarryIn = cin;
        Sub     = sub;
        waits   = 0;
        for (int t = 0; t < 64; t++) begin
            @(negedge Clock);
            if (InReady) begin
                exp_q.push_back(exp);
                @(posedge Clock);
                #1;
                return;
            end
            @(posedge Clock);
            #1;
            waits++;
        end
        total_cnt++;
        $display("FAIL send_timeout: operand not accepted after %0d cycles, required acceptance", waits);
    endtask

    task automatic idle(input int n);
        InValid = 1'b0;
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic drain();
        InValid = 1'b0;
        for (int t = 0; t < 64 && exp_q.size() != 0; t++) begin
            @(posedge Clock);
            #1;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Single operation from an idle pipe: result must appear after exactly STAGES edges.
    task automatic run_latency(input int idx);
        InValid = 1'b1;
        X       = vecs[idx].x;
        Y       = vecs[idx].y;
        CarryIn = vecs[idx].cin;
        Sub     = vecs[idx].sub;
        exp_q.push_back({vecs[idx].cout, vecs[idx].sum});
        @(negedge Clock);
        check("lat_inready", InReady, 1);
        @(posedge Clock);
        #1;
        InValid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            @(negedge Clock);
            check("lat_outvalid_early", OutValid, 0);
            @(posedge Clock);
            #1;
        end
        @(negedge Clock);
        check("lat_outvalid_on_time", OutValid, 1);
        @(posedge Clock);
        #1;
    endtask

`ifdef PIPE_ADDER_OVERFLOW_EN
    task automatic check_overflow(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic exp_ovf);
        int  w;
        bit  seen;
        send(x, y, 1'b0, 1'b0, model(x, y, 1'b0, 1'b0), w);
        InValid = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge Clock);
            if (OutValid) begin
                seen = 1'b1;
                check("overflow", Overflow, exp_ovf);
            end
            @(posedge Clock);
            #1;
        end
        if (!seen) begin
            total_cnt++;
            $display("FAIL overflow_timeout: OutValid 0, required 1 within 20 cycles");
        end
    endtask
`endif

    // ---------------- test sequence ----------------
    initial begin
        int               w;
        int               stalls;
        int               acc;
        int               seen0;
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] ry;
        logic             rc;
        logic             rs;

        //            x                         y                         cin   sub   sum                       cout
        vecs[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
        vecs[1]  = '{64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[2]  = '{64'h0000_0000_0000_0007, 64'h0000_0000_0000_0005, 1'b0, 1'b1, 64'h0000_0000_0000_0002, 1'b1};
        vecs[3]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 1'b0};
        vecs[4]  = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 64'h0000_0001_0000_0000, 1'b0};
        vecs[5]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0000_0000_0000_0000, 1'b1};
        vecs[6]  = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0};
        vecs[7]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 64'h0000_0000_0000_0000, 1'b1};
        vecs[8]  = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[9]  = '{64'h0000_0000_0000_000A, 64'h0000_0000_0000_0003, 1'b1, 1'b1, 64'h0000_0000_0000_0007, 1'b1};
        vecs[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[11] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 64'h0001_0000_0001_0000, 1'b0};

        // Reset state
        do_reset();
        check("reset_outvalid", OutValid, 0);
        check("reset_sum", Sum, 0);
        check("reset_carryout", CarryOut, 0);
        check("reset_inready", InReady, 1);

        // Latency from idle, full carry ripple through all stages
        run_latency(0);
        idle(2);

        // Table vectors streamed back-to-back
        stalls = 0;
        for (int i = 0; i < NVEC; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, {vecs[i].cout, vecs[i].sum}, w);
            stalls += w;
        end
        InValid = 1'b0;
        check("table_stream_stalls", stalls, 0);
        drain();

        // Random streaming: one accept and one result per cycle
        stalls = 0;
        seen0  = results_seen;
        for (int i = 0; i < 40; i++) begin
            rx = {$urandom, $urandom};
            ry = (i % 4 == 0) ? ~rx : {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(rx, ry, rc, rs, model(rx, ry, rc, rs), w);
            stalls += w;
        end
        InValid = 1'b0;
        check("stream_stalls", stalls, 0);
        check("stream_throughput", results_seen - seen0, 36);
        drain();
        check("stream_result_count", results_seen - seen0, 40);

        // Backpressure: sink blocked for 10 cycles while source keeps offering
        OutReady = 1'b0;
        acc      = 0;
        rx = {$urandom, $urandom};
        ry = {$urandom, $urandom};
        InValid = 1'b1;
        X = rx; Y = ry; CarryIn = 1'b0; Sub = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("bp_inready", InReady, (i < STAGES) ? 1 : 0);
            if (InReady) begin
                exp_q.push_back(model(X, Y, CarryIn, Sub));
                acc++;
            end
            @(posedge Clock);
            #1;
            X   = {$urandom, $urandom};
            Y   = {$urandom, $urandom};
            Sub = 1'($urandom_range(0, 1));
        end
        InValid = 1'b0;
        check("bp_accepted", acc, STAGES);
        OutReady = 1'b1;
        drain();

        // Random sink stalls while streaming
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    rx = {$urandom, $urandom};
                    ry = {$urandom, $urandom};
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    send(rx, ry, rc, rs, model(rx, ry, rc, rs), w);
                end
                InValid = 1'b0;
            end
            begin
                repeat (60) begin
                    @(posedge Clock);
                    #1;
                    OutReady = 1'($urandom_range(0, 1));
                end
                OutReady = 1'b1;
            end
        join
        drain();

        // Reset with one result at the output and three more in flight
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].x, vecs[i].y, vecs[i].cin, vecs[i].sub, {vecs[i].cout, vecs[i].sum}, w);
        end
        InValid = 1'b0;
        check("rst_pre_outvalid", OutValid, 1);
        Reset = 1'b1;
        #1;
        check("rst_async_outvalid", OutValid, 0);
        check("rst_async_sum", Sum, 0);
        check("rst_async_carryout", CarryOut, 0);
        exp_q.delete();
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        seen0 = results_seen;
        idle(8);
        check("rst_no_stale_result", results_seen - seen0, 0);
        run_latency(2);
        idle(2);

`ifdef PIPE_ADDER_OVERFLOW_EN
        check_overflow(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1);
        check_overflow(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b0);
        check_overflow(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
`endif

        drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
